// File: rtl/bp_be_fe_queue_buffer.sv
// ============================================================================
// bp_be_fe_queue_buffer : checkpointing FIFO between the FE queue and issue
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_be_fe_queue_buffer #(
  parameter int fe_queue_width_p = 128,
  parameter int els_p            = 8,
  localparam int ptr_width_lp    = $clog2(els_p) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [fe_queue_width_p-1:0] fe_queue_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_ready_o,
  output logic [fe_queue_width_p-1:0] fe_queue_o,
  output logic                        fe_queue_v_o,
  input  logic                        fe_queue_yumi_i,
  input  logic                        commit_v_i,
  input  logic                        roll_v_i,
  input  logic                        clr_v_i,
  output logic [ptr_width_lp-1:0]     count_o
);

  localparam logic [ptr_width_lp-1:0] c_els = ptr_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] c_one = ptr_width_lp'(1);

  logic [fe_queue_width_p-1:0] mem_q [els_p];
  logic [ptr_width_lp-1:0]     wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]     rptr_q, rptr_d;
  logic [ptr_width_lp-1:0]     cptr_q, cptr_d;

  logic                        enq, deq, cmt;
  logic [ptr_width_lp-2:0]     widx, ridx;

  assign widx = wptr_q[ptr_width_lp-2:0];
  assign ridx = rptr_q[ptr_width_lp-2:0];

  // Status depends only on registered pointers, never on this cycle's inputs.
  assign count_o          = wptr_q - cptr_q;
  assign fe_queue_ready_o = (count_o != c_els);
  assign fe_queue_v_o     = (rptr_q != wptr_q);
  assign fe_queue_o       = mem_q[ridx];

  assign enq = fe_queue_v_i & fe_queue_ready_o;
  assign deq = fe_queue_yumi_i & fe_queue_v_o;
  assign cmt = commit_v_i & (cptr_q != rptr_q);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (enq) wptr_d = wptr_q + c_one;
    if (clr_v_i) begin
      // An entry enqueued this cycle is discarded along with the rest.
      rptr_d = wptr_d;
      cptr_d = wptr_d;
    end else begin
      if (cmt) cptr_d = cptr_q + c_one;
      if (roll_v_i)  rptr_d = cptr_d;
      else if (deq)  rptr_d = rptr_q + c_one;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
      if (enq) mem_q[widx] <= fe_queue_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_be_fe_queue_buffer.sv
// ============================================================================
// tb_bp_be_fe_queue_buffer : directed self-checking bench
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_be_fe_queue_buffer;

  localparam int W   = 128;
  localparam int ELS = 8;
  localparam int PW  = $clog2(ELS) + 1;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [W-1:0]  fe_queue_i;
  logic          fe_queue_v_i;
  logic          fe_queue_ready_o;
  logic [W-1:0]  fe_queue_o;
  logic          fe_queue_v_o;
  logic          fe_queue_yumi_i;
  logic          commit_v_i;
  logic          roll_v_i;
  logic          clr_v_i;
  logic [PW-1:0] count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int ex;

  bp_be_fe_queue_buffer #(.fe_queue_width_p(W), .els_p(ELS)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .commit_v_i       (commit_v_i),
    .roll_v_i         (roll_v_i),
    .clr_v_i          (clr_v_i),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fe_queue_i = '0; fe_queue_v_i = 1'b0; fe_queue_yumi_i = 1'b0;
    commit_v_i = 1'b0; roll_v_i = 1'b0; clr_v_i = 1'b0;
  endtask

  // Advance one rising edge and settle; inputs return to idle.
  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic enq(input logic [W-1:0] d);
    fe_queue_i = d; fe_queue_v_i = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    reset_n_i = 1'b0;
    #12;
    chk("rst_ready", W'(fe_queue_ready_o), W'(1));
    chk("rst_v",     W'(fe_queue_v_o),     W'(0));
    chk("rst_count", W'(count_o),          W'(0));
    chk("rst_data",  fe_queue_o,           W'(0));
    #5 reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Fill 1..8; 9 must be held off
    for (int i = 1; i <= 8; i++) enq(W'(i));
    chk("fill_count", W'(count_o), W'(8));
    chk("fill_ready", W'(fe_queue_ready_o), W'(0));
    chk("fill_head",  fe_queue_o, W'(1));
    fe_queue_i = W'(9); fe_queue_v_i = 1'b1; fe_queue_yumi_i = 1'b1;
    tick();
    chk("full_hold_count", W'(count_o), W'(8));
    chk("full_hold_ready", W'(fe_queue_ready_o), W'(0));
    chk("full_deq_head",   fe_queue_o, W'(2));
    commit_v_i = 1'b1;
    tick();
    chk("commit_ready", W'(fe_queue_ready_o), W'(1));
    chk("commit_count", W'(count_o), W'(7));
    enq(W'(9));
    chk("accept9_count", W'(count_o), W'(8));
    chk("accept9_ready", W'(fe_queue_ready_o), W'(0));
    clr_v_i = 1'b1;
    tick();
    chk("clr1_count", W'(count_o), W'(0));
    chk("clr1_v",     W'(fe_queue_v_o), W'(0));

    // Roll replay
    for (int i = 0; i < 4; i++) enq(W'(8'hA + i));
    chk("roll_deqA", fe_queue_o, W'(8'hA));
    fe_queue_yumi_i = 1'b1; tick();
    chk("roll_deqB", fe_queue_o, W'(8'hB));
    fe_queue_yumi_i = 1'b1; tick();
    commit_v_i = 1'b1; tick();
    chk("roll_pre_count", W'(count_o), W'(3));
    roll_v_i = 1'b1; tick();
    chk("roll_head",  fe_queue_o, W'(8'hB));
    chk("roll_count", W'(count_o), W'(3));
    for (int i = 0; i < 3; i++) begin
      chk("replay_data", fe_queue_o, W'(8'hB + i));
      chk("replay_v",    W'(fe_queue_v_o), W'(1));
      fe_queue_yumi_i = 1'b1; tick();
    end
    chk("replay_empty", W'(fe_queue_v_o), W'(0));
    chk("replay_count", W'(count_o), W'(3));
    for (int i = 0; i < 3; i++) begin commit_v_i = 1'b1; tick(); end
    chk("replay_commit_count", W'(count_o), W'(0));

    // Clear with a simultaneous enqueue
    for (int i = 0; i < 5; i++) enq(W'(8'h21 + i));
    chk("pre_clr_count", W'(count_o), W'(5));
    fe_queue_i = W'(8'hEE); fe_queue_v_i = 1'b1; clr_v_i = 1'b1;
    tick();
    chk("clr_v",     W'(fe_queue_v_o), W'(0));
    chk("clr_count", W'(count_o), W'(0));
    chk("clr_ready", W'(fe_queue_ready_o), W'(1));
    tick();
    chk("clr_ee_hidden", W'(fe_queue_v_o), W'(0));

    // Illegal controls
    fe_queue_yumi_i = 1'b1; tick();
    chk("ill_yumi_v",     W'(fe_queue_v_o), W'(0));
    chk("ill_yumi_count", W'(count_o), W'(0));
    enq(W'(8'h31));
    chk("ill_yumi_data", fe_queue_o, W'(8'h31));
    chk("ill_yumi_v2",   W'(fe_queue_v_o), W'(1));
    commit_v_i = 1'b1; tick();
    chk("ill_commit_count", W'(count_o), W'(1));
    enq(W'(8'h32));
    fe_queue_yumi_i = 1'b1; tick();
    chk("ill_pre_roll", fe_queue_o, W'(8'h32));
    roll_v_i = 1'b1; fe_queue_yumi_i = 1'b1; tick();
    chk("ill_roll_yumi_data",  fe_queue_o, W'(8'h31));
    chk("ill_roll_yumi_count", W'(count_o), W'(2));
    clr_v_i = 1'b1; tick();

    // Streaming wrap-around
    ex = 0;
    for (int k = 0; k < 20; k++) begin
      chk("wrap_ready", W'(fe_queue_ready_o), W'(1));
      if (fe_queue_v_o) begin
        chk("wrap_data", fe_queue_o, W'(12'h100 + ex));
        ex++;
        fe_queue_yumi_i = 1'b1;
      end
      fe_queue_i = W'(12'h100 + k); fe_queue_v_i = 1'b1; commit_v_i = 1'b1;
      tick();
      if (k >= 2) chk("wrap_count", W'(count_o), W'(2));
    end
    for (int b = 0; b < 10 && count_o != '0; b++) begin
      if (fe_queue_v_o) begin
        chk("drain_data", fe_queue_o, W'(12'h100 + ex));
        ex++;
        fe_queue_yumi_i = 1'b1;
      end
      commit_v_i = 1'b1;
      tick();
    end
    chk("drain_total", W'(ex), W'(20));
    chk("drain_count", W'(count_o), W'(0));
    chk("drain_v",     W'(fe_queue_v_o), W'(0));
    for (int i = 0; i < 8; i++) enq(W'(12'h200 + i));
    chk("wrap_full_ready", W'(fe_queue_ready_o), W'(0));
    chk("wrap_full_count", W'(count_o), W'(8));
    chk("wrap_full_head",  fe_queue_o, W'(12'h200));

    // Asynchronous reset mid-operation: 6 held, 3 dequeued
    clr_v_i = 1'b1; tick();
    for (int i = 0; i < 6; i++) enq(W'(8'h61 + i));
    for (int i = 0; i < 3; i++) begin fe_queue_yumi_i = 1'b1; tick(); end
    chk("pre_rst_data",  fe_queue_o, W'(8'h64));
    chk("pre_rst_count", W'(count_o), W'(6));
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_ready", W'(fe_queue_ready_o), W'(1));
    chk("arst_v",     W'(fe_queue_v_o), W'(0));
    chk("arst_count", W'(count_o), W'(0));
    chk("arst_data",  fe_queue_o, W'(0));
    fe_queue_i = W'(8'h55); fe_queue_v_i = 1'b1;
    tick();
    chk("in_rst_count", W'(count_o), W'(0));
    chk("in_rst_ready", W'(fe_queue_ready_o), W'(1));
    #2 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    fe_queue_i = W'(8'h77); fe_queue_v_i = 1'b1;
    chk("no_bypass_v", W'(fe_queue_v_o), W'(0));
    tick();
    chk("post_rst_data",  fe_queue_o, W'(8'h77));
    chk("post_rst_v",     W'(fe_queue_v_o), W'(1));
    chk("post_rst_count", W'(count_o), W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
